// File: rtl/ibexsis_pkg.sv
// Shared types and constants for the Ibex data-port to AXI4-lite peripheral bridge.
package ibexsis_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP
  } dmem_axi_state_e;

  // Peripheral window: IOmodule base up to the end of Timer1 (exclusive).
  localparam logic [31:0] ADDR_LO = 32'h0000_4000;
  localparam logic [31:0] ADDR_HI = 32'h0000_40D8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic in_periph_window(input logic [31:0] addr);
    return (addr >= ADDR_LO) && (addr < ADDR_HI);
  endfunction

endpackage

// File: rtl/dmem_axi_wdog.sv
// Bus watchdog for dmem_axi_bridge: counts cycles spent waiting on the AXI slave
// and flags expiry once TIMEOUT_CYCLES cycles have elapsed since the count started.
module dmem_axi_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic run_i,
  output logic expired_o
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = 8'd0;
    end else if (run_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Expiry is taken in the cycle the count would step to TIMEOUT_CYCLES.
  assign expired_o = run_i && !clear_i && (cnt_q == LIMIT);

  // NOTE: sequential state only ever uses non-blocking assignments.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_axi_bridge.sv
// Single-outstanding bridge from the Ibex data port (req/gnt/rvalid) to AXI4-lite.
// Optional bus watchdog enabled by defining DMEM_AXI_BRIDGE_TIMEOUT_EN.
module dmem_axi_bridge
  import ibexsis_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        data_err,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  input  logic [1:0]  bresp,
  output logic        bready,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic        rvalid,
  input  logic [1:0]  rresp,
  input  logic [31:0] rdata,
  output logic        rready
);

  dmem_axi_state_e state_d, state_q;
  logic [31:2] addr_d, addr_q;
  logic [3:0]  be_d, be_q;
  logic [31:0] wdata_d, wdata_q;
  logic        awvalid_d, awvalid_q;
  logic        wvalid_d, wvalid_q;
  logic        arvalid_d, arvalid_q;
  logic        rsp_valid_d, rsp_valid_q;
  logic [31:0] rsp_rdata_d, rsp_rdata_q;
  logic        rsp_err_d, rsp_err_q;

  logic in_window;
  logic accept;
  logic wdog_expired;

  assign in_window = in_periph_window(data_addr);
  assign accept    = (state_q == IDLE) && data_req;

`ifdef DMEM_AXI_BRIDGE_TIMEOUT_EN
  logic wdog_run;

  assign wdog_run = (state_q == WR_ADDR_DATA) || (state_q == WR_RESP) ||
                    (state_q == RD_ADDR)      || (state_q == RD_DATA);

  dmem_axi_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (accept && in_window),
    .run_i    (wdog_run),
    .expired_o(wdog_expired)
  );
`else
  logic [7:0] unused_timeout;

  assign unused_timeout = 8'(TIMEOUT_CYCLES);
  assign wdog_expired   = 1'b0;
`endif

  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (data_req) begin
          addr_d  = data_addr[31:2];
          be_d    = data_be;
          wdata_d = data_wdata;
          if (!in_window) begin
            rsp_rdata_d = 32'd0;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end else if (data_we) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_ADDR_DATA;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end

      // AW and W complete independently; leave once both have handshaken.
      WR_ADDR_DATA: begin
        if (awready) awvalid_d = 1'b0;
        if (wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = WR_RESP;
      end

      WR_RESP: begin
        if (bvalid) begin
          rsp_rdata_d = 32'd0;
          rsp_err_d   = (bresp != RESP_OKAY);
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end

      RD_ADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          state_d   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (rvalid) begin
          rsp_rdata_d = rdata;
          rsp_err_d   = (rresp != RESP_OKAY);
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A stalled slave is abandoned; any response it sends later lands outside
    // WR_RESP/RD_DATA and is dropped.
    if (wdog_expired) begin
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      arvalid_d   = 1'b0;
      rsp_rdata_d = 32'd0;
      rsp_err_d   = 1'b1;
      rsp_valid_d = 1'b1;
      state_d     = RESP;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      be_q        <= 4'd0;
      wdata_q     <= 32'd0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // NOTE: the combinational outputs are qualified with rst_ni so that every
  // output reads 0 while reset is held, not only the registered ones.
  assign data_gnt    = accept && rst_ni;
  assign bready      = rst_ni;
  assign rready      = rst_ni;

  assign data_rvalid = rsp_valid_q;
  assign data_rdata  = rsp_rdata_q;
  assign data_err    = rsp_err_q;
  assign awaddr      = {addr_q, 2'b00};
  assign araddr      = {addr_q, 2'b00};
  assign awvalid     = awvalid_q;
  assign wvalid      = wvalid_q;
  assign arvalid     = arvalid_q;
  assign wdata       = wdata_q;
  assign wstrb       = be_q;

endmodule

// File: tb/tb_dmem_axi_bridge.sv
// Directed scoreboard bench for dmem_axi_bridge; the timeout scenario runs
// when DMEM_AXI_BRIDGE_TIMEOUT_EN is defined.
module tb_dmem_axi_bridge;
  import ibexsis_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        data_req, data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata;
  logic        data_gnt, data_rvalid, data_err;
  logic [31:0] data_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int   n_vec = 0;
  int   n_err = 0;
  rsp_t sb[$];
  logic any_valid;
  int   n;

  always #5 clk = ~clk;

  dmem_axi_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .data_req(data_req), .data_we(data_we), .data_be(data_be),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .data_err(data_err),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rvalid(rvalid), .rresp(rresp), .rdata(rdata), .rready(rready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] be);
    data_req   = 1'b1;
    data_we    = we;
    data_addr  = addr;
    data_wdata = wd;
    data_be    = be;
  endtask

  // Response monitor: every data_rvalid must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_ni && data_rvalid) begin
      check("rsp_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        rsp_t e;
        e = sb.pop_front();
        check("rsp_rdata", data_rdata, e.rdata);
        check("rsp_err", 32'(data_err), 32'(e.err));
      end
    end
    if (awvalid || wvalid || arvalid) any_valid = 1'b1;
  end

  initial begin
    rst_ni = 1'b0;
    data_req = 1'b0; data_we = 1'b0; data_be = 4'd0;
    data_addr = 32'd0; data_wdata = 32'd0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = 32'd0;
    any_valid = 1'b0;

    // Reset state, with a request pending to show the grant is suppressed.
    repeat (3) @(posedge clk);
    #1;
    drive_req(1'b0, 32'h4000, 32'd0, 4'hF);
    #1;
    check("rst_gnt", 32'(data_gnt), 32'd0);
    check("rst_rvalid", 32'(data_rvalid), 32'd0);
    check("rst_bready", 32'(bready), 32'd0);
    check("rst_axi_valids", {29'd0, awvalid, wvalid, arvalid}, 32'd0);
    data_req = 1'b0;
    rst_ni   = 1'b1;
    tick();

    // Zero-wait write.
    drive_req(1'b1, 32'h4008, 32'hA5A5_0001, 4'hF);
    awready = 1'b1; wready = 1'b1;
    #1;
    check("wr_gnt_c0", 32'(data_gnt), 32'd1);
    sb.push_back('{rdata: 32'd0, err: 1'b0});
    tick();
    check("wr_gnt_busy", 32'(data_gnt), 32'd0);
    data_req = 1'b0;
    check("wr_aw_w_valid", {30'd0, awvalid, wvalid}, 32'd3);
    check("wr_awaddr", awaddr, 32'h4008);
    check("wr_wstrb", 32'(wstrb), 32'hF);
    check("wr_wdata", wdata, 32'hA5A5_0001);
    tick();
    check("wr_valids_drop", {30'd0, awvalid, wvalid}, 32'd0);
    bvalid = 1'b1; bresp = RESP_OKAY;
    tick();
    bvalid = 1'b0;
    check("wr_rvalid_c3", 32'(data_rvalid), 32'd1);
    tick();
    check("wr_rvalid_1cyc", 32'(data_rvalid), 32'd0);
    awready = 1'b0; wready = 1'b0;

    // Read with arready held off for 4 cycles; a stray rvalid in RD_ADDR is ignored.
    drive_req(1'b0, 32'h4018, 32'd0, 4'hF);
    #1;
    check("rd_gnt", 32'(data_gnt), 32'd1);
    sb.push_back('{rdata: 32'h1234, err: 1'b0});
    for (int i = 1; i <= 5; i++) begin
      tick();
      data_req = 1'b0;
      rvalid   = (i == 2);
      rdata    = (i == 2) ? 32'hDEAD_BEEF : 32'd0;
      if (i == 5) arready = 1'b1;
      check("rd_ar_hold", 32'(arvalid), 32'd1);
      if (i == 1) check("rd_araddr", araddr, 32'h4018);
    end
    tick();
    arready = 1'b0;
    check("rd_ar_done", 32'(arvalid), 32'd0);
    rvalid = 1'b1; rdata = 32'h1234; rresp = RESP_OKAY;
    tick();
    rvalid = 1'b0;
    check("rd_rvalid", 32'(data_rvalid), 32'd1);
    tick();
    check("rd_rvalid_1cyc", 32'(data_rvalid), 32'd0);

    // Unmapped read then back-to-back unmapped write.
    any_valid = 1'b0;
    drive_req(1'b0, 32'h0000_3FFC, 32'd0, 4'hF);
    #1;
    check("unm_rd_gnt", 32'(data_gnt), 32'd1);
    sb.push_back('{rdata: 32'd0, err: 1'b1});
    tick();
    check("unm_rd_rvalid_c1", 32'(data_rvalid), 32'd1);
    drive_req(1'b1, 32'h40D8, 32'h1111_2222, 4'hF);
    #1;
    check("unm_gnt_in_resp", 32'(data_gnt), 32'd0);
    tick();
    check("unm_wr_gnt_b2b", 32'(data_gnt), 32'd1);
    sb.push_back('{rdata: 32'd0, err: 1'b1});
    tick();
    data_req = 1'b0;
    check("unm_wr_rvalid_c1", 32'(data_rvalid), 32'd1);
    tick();
    check("unm_no_axi", 32'(any_valid), 32'd0);

    // W accepted two cycles before AW, then SLVERR.
    drive_req(1'b1, 32'h4010, 32'h5A5A_0F0F, 4'h3);
    wready = 1'b1;
    #1;
    check("split_gnt", 32'(data_gnt), 32'd1);
    sb.push_back('{rdata: 32'd0, err: 1'b1});
    tick();
    data_req = 1'b0;
    check("split_c1_valids", {30'd0, awvalid, wvalid}, 32'd3);
    tick();
    wready = 1'b0;
    check("split_w_first", {30'd0, awvalid, wvalid}, 32'd2);
    tick();
    awready = 1'b1;
    check("split_aw_held", {30'd0, awvalid, wvalid}, 32'd2);
    check("split_wstrb", 32'(wstrb), 32'h3);
    tick();
    awready = 1'b0;
    check("split_aw_done", 32'(awvalid), 32'd0);
    bvalid = 1'b1; bresp = RESP_SLVERR;
    tick();
    bvalid = 1'b0; bresp = RESP_OKAY;
    check("split_rvalid", 32'(data_rvalid), 32'd1);
    tick();

    // Reset asserted in RD_DATA, then a fresh read.
    drive_req(1'b0, 32'h4020, 32'd0, 4'hF);
    arready = 1'b1;
    #1;
    check("rrst_gnt", 32'(data_gnt), 32'd1);
    tick();
    data_req = 1'b0;
    check("rrst_arvalid", 32'(arvalid), 32'd1);
    tick();
    arready = 1'b0;
    check("rrst_in_rd_data", 32'(arvalid), 32'd0);
    rst_ni   = 1'b0;
    data_req = 1'b1;
    #1;
    check("rrst_araddr", araddr, 32'd0);
    check("rrst_awaddr", awaddr, 32'd0);
    check("rrst_gnt0", 32'(data_gnt), 32'd0);
    check("rrst_ready", {30'd0, bready, rready}, 32'd0);
    check("rrst_rsp", {data_rdata[30:0], data_err}, 32'd0);
    check("rrst_wstrb_wdata", wdata | 32'(wstrb), 32'd0);
    tick();
    rst_ni = 1'b1;
    drive_req(1'b0, 32'h4004, 32'd0, 4'hF);
    arready = 1'b1;
    #1;
    check("post_rst_gnt", 32'(data_gnt), 32'd1);
    sb.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0});
    tick();
    data_req = 1'b0;
    check("post_rst_araddr", araddr, 32'h4004);
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'hCAFE_F00D; rresp = RESP_OKAY;
    tick();
    rvalid = 1'b0;
    check("post_rst_rvalid", 32'(data_rvalid), 32'd1);
    tick();

`ifdef DMEM_AXI_BRIDGE_TIMEOUT_EN
    // Slave never answers B: timeout after 16 counted cycles, late B ignored.
    drive_req(1'b1, 32'h4030, 32'h0BAD_0BAD, 4'hF);
    awready = 1'b1; wready = 1'b1;
    #1;
    check("to_gnt", 32'(data_gnt), 32'd1);
    sb.push_back('{rdata: 32'd0, err: 1'b1});
    n = 0;
    do begin
      tick();
      data_req = 1'b0;
      n++;
    end while (!data_rvalid && n < 100);
    check("to_latency", 32'(n), 32'd17);
    awready = 1'b0; wready = 1'b0;
    bvalid = 1'b1; bresp = RESP_OKAY;
    tick();
    check("to_late_b_c0", 32'(data_rvalid), 32'd0);
    tick();
    bvalid = 1'b0;
    check("to_late_b_c1", 32'(data_rvalid), 32'd0);
`endif

    repeat (3) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
